// File: rtl/retire_queue_if.sv
// Alloc / completion / retire bundle for retire_queue; master drives requests, slave is the queue.
// Widths track DEPTH and DATA_WIDTH so both ends agree on index and count sizes.
interface retire_queue_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [IDX_W-1:0]      alloc_id;
  logic                  cmpl_valid;
  logic [IDX_W-1:0]      cmpl_id;
  logic [DATA_WIDTH-1:0] cmpl_data;
  logic                  cmpl_err;
  logic                  retire_valid;
  logic                  retire_ready;
  logic [DATA_WIDTH-1:0] retire_data;
  logic [IDX_W-1:0]      retire_id;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W-1:0]      ready_run;

  modport master (
    output flush, alloc_valid, cmpl_valid, cmpl_id, cmpl_data, retire_ready,
    input  alloc_ready, alloc_id, cmpl_err, retire_valid, retire_data, retire_id,
           occupancy, ready_run
  );

  modport slave (
    input  flush, alloc_valid, cmpl_valid, cmpl_id, cmpl_data, retire_ready,
    output alloc_ready, alloc_id, cmpl_err, retire_valid, retire_data, retire_id,
           occupancy, ready_run
  );
endinterface

// File: rtl/retire_queue.sv
// In-order retire queue: allocs in order, completes out of order, retires from head one cycle after completion.
// Backpressure: alloc_ready drops only on full (never relieved by a same-cycle retire); retire holds until retire_ready.
module retire_queue #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  retire_queue_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W:0]        head_q, head_d;
  logic [IDX_W:0]        tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      head_idx, tail_idx;
  logic                  full, empty;
  logic                  alloc_fire, cmpl_ok, retire_fire, retire_vld;
  logic [IDX_W:0]        occ;
  logic [2*DEPTH-1:0]    done_dbl;
  logic [DEPTH-1:0]      done_rot;
  logic [DEPTH-1:0]      pref, nxt;
  logic [CNT_W-1:0]      run;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty    = (head_q == tail_q);

  // Legality is judged on pre-edge state, so a same-cycle alloc of cmpl_id is still invalid here.
  assign cmpl_ok     = bus.cmpl_valid && valid_q[bus.cmpl_id] && !done_q[bus.cmpl_id];
  assign retire_vld  = !empty && done_q[head_idx];
  assign alloc_fire  = bus.alloc_valid && !full;
  assign retire_fire = retire_vld && bus.retire_ready;

  assign occ = tail_q - head_q;

  // Rotate the done bitmap so bit 0 is the head entry.
  assign done_dbl = {done_q, done_q} >> head_idx;
  assign done_rot = done_dbl[DEPTH-1:0];

  // Kogge-Stone prefix-AND: pref[i] = AND of done_rot[0..i]; slots past the tail are never done.
  always_comb begin
    pref = done_rot;
    nxt  = '0;
    for (int s = 0; s < IDX_W; s++) begin
      nxt = pref;
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= (1 << s)) begin
          nxt[IDX_W'(i)] = pref[IDX_W'(i)] & pref[IDX_W'(i - (1 << s))];
        end
      end
      pref = nxt;
    end
  end

  always_comb begin
    run = '0;
    for (int i = 0; i < DEPTH; i++) begin
      run = run + CNT_W'(pref[IDX_W'(i)]);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = bus.cmpl_valid && !cmpl_ok;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
      err_d   = 1'b0;
    end else begin
      // Alloc, completion and retire always touch distinct entries, so their order here is irrelevant.
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + (IDX_W+1)'(1);
      end
      if (cmpl_ok) begin
        done_d[bus.cmpl_id] = 1'b1;
      end
      if (retire_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + (IDX_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Payload storage carries no reset; it is only observed once its done bit is set.
  always_ff @(posedge clk_i) begin
    if (!bus.flush && cmpl_ok) begin
      data_q[bus.cmpl_id] <= bus.cmpl_data;
    end
  end

  assign bus.alloc_ready  = !full;
  assign bus.alloc_id     = tail_idx;
  assign bus.cmpl_err     = err_q;
  assign bus.retire_valid = retire_vld;
  assign bus.retire_data  = data_q[head_idx];
  assign bus.retire_id    = head_idx;
  assign bus.occupancy    = CNT_W'(occ);
  assign bus.ready_run    = run;
endmodule

// File: tb/tb_retire_queue.sv
// Bench for retire_queue at DEPTH=4: directed vectors with literal checks plus a per-cycle
// comparison against a queue-of-ids model of in-order retirement.
module tb_retire_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  retire_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  retire_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: ids in allocation order plus per-id flags and payload.
  int          m_q[$];
  bit          m_valid [DEPTH];
  bit          m_done  [DEPTH];
  logic [31:0] m_data  [DEPTH];
  int          m_tail;
  bit          m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_done[i]  = 1'b0;
      end
      m_tail = 0;
      m_err  = 1'b0;
    end else begin
      bit a_f, c_ok, r_f;
      int cid, h;
      cid  = int'(bus.cmpl_id);
      a_f  = bus.alloc_valid && (m_q.size() < DEPTH);
      c_ok = bus.cmpl_valid && m_valid[cid] && !m_done[cid];
      r_f  = bus.retire_ready && (m_q.size() > 0) && m_done[m_q[0]];
      if (bus.flush) begin
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
          m_valid[i] = 1'b0;
          m_done[i]  = 1'b0;
        end
        m_tail = 0;
        m_err  = 1'b0;
      end else begin
        m_err = bus.cmpl_valid && !c_ok;
        if (c_ok) begin
          m_done[cid] = 1'b1;
          m_data[cid] = bus.cmpl_data;
        end
        if (r_f) begin
          h = m_q.pop_front();
          m_valid[h] = 1'b0;
          m_done[h]  = 1'b0;
        end
        if (a_f) begin
          m_q.push_back(m_tail);
          m_valid[m_tail] = 1'b1;
          m_done[m_tail]  = 1'b0;
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int  rr;
      bit  rv;
      rr = 0;
      while (rr < m_q.size() && m_done[m_q[rr]]) rr++;
      rv = (m_q.size() > 0) && m_done[m_q[0]];
      chk("occupancy",    32'(bus.occupancy),    m_q.size());
      chk("ready_run",    32'(bus.ready_run),    rr);
      chk("alloc_ready",  32'(bus.alloc_ready),  32'(m_q.size() < DEPTH));
      chk("alloc_id",     32'(bus.alloc_id),     m_tail);
      chk("retire_valid", 32'(bus.retire_valid), 32'(rv));
      chk("retire_id",    32'(bus.retire_id),    (m_q.size() > 0) ? m_q[0] : m_tail);
      chk("cmpl_err",     32'(bus.cmpl_err),     32'(m_err));
      if (rv) chk("retire_data", bus.retire_data, m_data[m_q[0]]);
    end
  end

  task automatic idle();
    bus.flush        = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.cmpl_valid   = 1'b0;
    bus.cmpl_id      = '0;
    bus.cmpl_data    = '0;
    bus.retire_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cmpl(input int id, input logic [31:0] d);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_id    = 2'(id);
    bus.cmpl_data  = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alloc_ready"},  32'(bus.alloc_ready),  1);
    chk({tag, "_alloc_id"},     32'(bus.alloc_id),     0);
    chk({tag, "_retire_valid"}, 32'(bus.retire_valid), 0);
    chk({tag, "_retire_id"},    32'(bus.retire_id),    0);
    chk({tag, "_occupancy"},    32'(bus.occupancy),    0);
    chk({tag, "_ready_run"},    32'(bus.ready_run),    0);
    chk({tag, "_cmpl_err"},     32'(bus.cmpl_err),     0);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("rst");
    rst = 1'b0;
    cmp_en = 1'b1;

    // Fill: ids 0..3, then a refused fifth alloc.
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_valid = 1'b1;
      chk("fill_alloc_id", 32'(bus.alloc_id), i);
      cyc();
    end
    chk("full_alloc_ready", 32'(bus.alloc_ready), 0);
    chk("full_occupancy",   32'(bus.occupancy),   4);
    chk("full_ready_run",   32'(bus.ready_run),   0);
    bus.alloc_valid = 1'b1;
    cyc();
    chk("refused_occupancy", 32'(bus.occupancy), 4);
    chk("refused_alloc_id",  32'(bus.alloc_id),  0);

    // Out-of-order completion; head gap keeps retire low.
    cmpl(2, 32'hB2); cyc();
    cmpl(1, 32'hB1); cyc();
    chk("gap_retire_valid", 32'(bus.retire_valid), 0);
    chk("gap_ready_run",    32'(bus.ready_run),    0);
    cmpl(0, 32'hB0); cyc();
    chk("run3_retire_valid", 32'(bus.retire_valid), 1);
    chk("run3_ready_run",    32'(bus.ready_run),    3);
    chk("run3_retire_data",  bus.retire_data,       32'hB0);

    // Full with head done: retire fires, alloc refused.
    bus.retire_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    cyc();
    chk("rf_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rf_alloc_id",    32'(bus.alloc_id),    0);
    chk("rf_occupancy",   32'(bus.occupancy),   3);
    chk("rf_retire_data", bus.retire_data,      32'hB1);
    bus.retire_ready = 1'b1; cyc();
    chk("ret2_retire_data", bus.retire_data, 32'hB2);
    bus.retire_ready = 1'b1; cyc();
    chk("ret3_retire_valid", 32'(bus.retire_valid), 0);
    chk("ret3_occupancy",    32'(bus.occupancy),    1);

    // Illegal completions: unallocated id, then already-done id.
    cmpl(0, 32'hEE); cyc();
    chk("unalloc_err", 32'(bus.cmpl_err), 1);
    cyc();
    chk("unalloc_err_clear", 32'(bus.cmpl_err), 0);
    cmpl(3, 32'hC3); cyc();
    chk("c3_err",         32'(bus.cmpl_err),  0);
    chk("c3_retire_data", bus.retire_data,    32'hC3);
    cmpl(3, 32'hDEAD); cyc();
    chk("redone_err",  32'(bus.cmpl_err), 1);
    chk("redone_data", bus.retire_data,   32'hC3);
    cyc();
    chk("redone_err_clear", 32'(bus.cmpl_err), 0);
    bus.retire_ready = 1'b1; cyc();
    chk("drain_occupancy", 32'(bus.occupancy), 0);

    // Completion to the index being allocated this cycle is illegal.
    bus.alloc_valid = 1'b1;
    cmpl(0, 32'h55); cyc();
    chk("samecyc_err",          32'(bus.cmpl_err),     1);
    chk("samecyc_occupancy",    32'(bus.occupancy),    1);
    chk("samecyc_retire_valid", 32'(bus.retire_valid), 0);

    // Random mix; the per-cycle compare tracks order, occupancy and run length.
    for (int n = 0; n < 40; n++) begin
      bus.alloc_valid  = ($urandom_range(0, 99) < 50);
      bus.retire_ready = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < 65) cmpl(int'($urandom_range(0, DEPTH - 1)), $urandom);
      cyc();
    end

    // Flush dominates concurrent handshakes.
    bus.alloc_valid = 1'b1; cyc();
    bus.flush        = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.retire_ready = 1'b1;
    cmpl(int'(bus.retire_id), 32'h99);
    cyc();
    chk("flush_occupancy",    32'(bus.occupancy),    0);
    chk("flush_retire_valid", 32'(bus.retire_valid), 0);
    chk("flush_alloc_id",     32'(bus.alloc_id),     0);
    chk("flush_cmpl_err",     32'(bus.cmpl_err),     0);
    bus.flush = 1'b1;
    cmpl(2, 32'h11); cyc();
    chk("flush_err_forced", 32'(bus.cmpl_err), 0);

    // Async reset mid-cycle with a non-trivial state.
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1; cyc();
    end
    cmpl(0, 32'h77); cyc();
    chk("pre_rst_retire_valid", 32'(bus.retire_valid), 1);
    chk("pre_rst_occupancy",    32'(bus.occupancy),    3);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("async");
    #2 rst = 1'b0;
    bus.alloc_valid = 1'b1; cyc();
    chk("post_rst_occupancy", 32'(bus.occupancy), 1);
    chk("post_rst_alloc_id",  32'(bus.alloc_id),  1);
    cyc();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
